// File: rtl/timestamp_capture_if.sv
// Timestamp stream from timestamp_capture to the packetiser: {epoch, count} words with valid/ready.
// EPOCH_W must match the EPOCH_W of the timestamp_capture instance driving it.
interface timestamp_capture_if #(
  parameter int EPOCH_W = 16
);
  localparam int TS_W = EPOCH_W + 32;

  logic [TS_W-1:0] ts_data;
  logic            ts_valid;
  logic            ts_ready;

  modport master (output ts_data, ts_valid, input ts_ready);
  modport slave  (input ts_data, ts_valid, output ts_ready);
endinterface

// File: rtl/timestamp_capture.sv
// Edge-triggered timestamp capture: {epoch, count} pushed into a small FWFT FIFO and streamed out.
// Define SIG_SYNC_EN to pass sig_in through a 2-flop synchroniser (adds 2 cycles of latency).
module timestamp_capture #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         EPOCH_W    = 16,
  parameter logic [1:0] EDGE_SEL   = 2'b01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          ena,
  input  logic [31:0]                   count,
  input  logic                          pulse_full,
  input  logic                          sig_in,
  timestamp_capture_if.master           ts,
  output logic                          ovf,
  output logic [7:0]                    drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TS_W = EPOCH_W + 32;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  logic               sig_s;
  logic               sig_d;
  logic [EPOCH_W-1:0] epoch;
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [LW-1:0]      level_after_pop;
  logic [TS_W-1:0]    mem [FIFO_DEPTH];
  logic [TS_W-1:0]    ts_data_q, head_nxt, entry;
  logic               rise, fall, ev, full, pop, push, drop;

`ifdef SIG_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
    end
  end

  assign sig_s = sync2;
`else
  assign sig_s = sig_in;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
  always_comb begin
    rise            = sig_s & ~sig_d;
    fall            = ~sig_s & sig_d;
    ev              = ena & ((rise & EDGE_SEL[0]) | (fall & EDGE_SEL[1]));
    full            = (fifo_level == LW'(FIFO_DEPTH));
    pop             = (fifo_level != '0) & ts.ts_ready & ~clr;
    push            = ev & ~clr & (~full | pop);
    drop            = ev & ~clr & full & ~pop;
    entry           = {epoch + EPOCH_W'(pulse_full), count};
    level_after_pop = fifo_level - LW'(pop);
    rd_ptr_nxt      = rd_ptr + AW'(pop);
    // Old memory contents are still valid at rd_ptr_nxt unless the FIFO drains to empty this cycle.
    head_nxt        = mem[rd_ptr_nxt];
    if (push && level_after_pop == '0) head_nxt = entry;
  end

  // NOTE: the storage array has no reset; the pointers and level alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_d      <= 1'b0;
      epoch      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ts_data_q  <= '0;
      ovf        <= 1'b0;
      drop_cnt   <= 8'h00;
    end else if (clr) begin
      sig_d      <= sig_s;
      epoch      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ts_data_q  <= '0;
      ovf        <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      sig_d      <= sig_s;
      epoch      <= epoch + EPOCH_W'(pulse_full);
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr_nxt;
      fifo_level <= level_after_pop + LW'(push);
      ts_data_q  <= head_nxt;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign ts.ts_data  = ts_data_q;
  assign ts.ts_valid = (fifo_level != '0);

endmodule
